irq_req_gen: RTL and testbench

- Interrupt request generator for the interrupt block: the transmitting end of the interrupt request/acknowledge path.
- Collects single-cycle event pulses from up to NUM_SRC edge-detected sources into pending flags.
- Applies a per-source enable mask and arbitrates by fixed priority (lowest index wins).
- Presents one level request with a stable source ID, held until the consumer acknowledges, then enforces a minimum deassertion gap.

---
 rtl/irq_req_gen_if.sv | 32 +++
 rtl/irq_req_gen.sv | 112 +++++++++++
 tb/tb_irq_req_gen.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/irq_req_gen_if.sv
// ============================================================================
// irq_req_gen_if : event inputs and request/acknowledge signals of irq_req_gen
// Rev 1.0
// ============================================================================
`default_nettype none

interface irq_req_gen_if #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
);
  logic [NUM_SRC-1:0] evt_pulse;
  logic [NUM_SRC-1:0] irq_en;
  logic               irq_ack;
  logic [NUM_SRC-1:0] ovf_clr;
  logic               irq_req;
  logic [ID_W-1:0]    irq_id;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] overflow;

  // The generator drives the request; the consumer answers with irq_ack.
  modport master (
    input  evt_pulse, irq_en, irq_ack, ovf_clr,
    output irq_req, irq_id, pending, overflow
  );

  modport slave (
    output evt_pulse, irq_en, irq_ack, ovf_clr,
    input  irq_req, irq_id, pending, overflow
  );
endinterface

`default_nettype wire

// File: rtl/irq_req_gen.sv
// ============================================================================
// irq_req_gen : pending/overflow capture, fixed-priority arbitration, level req
// Rev 1.0
// ============================================================================
`default_nettype none

module irq_req_gen #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3,
  parameter int MIN_GAP = 2
) (
  input  wire logic       clk,
  input  wire logic       rst,
  irq_req_gen_if.master   bus
);

  localparam int              GAP_W    = $clog2(MIN_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_req;
  logic [ID_W-1:0]    r_id;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_overflow;

  logic [NUM_SRC-1:0] w_ack_hit;
  logic [NUM_SRC-1:0] w_elig;
  logic [ID_W-1:0]    w_sel_id;

  assign w_elig = r_pending & bus.irq_en;

  // One-hot of the source whose request is being acknowledged this cycle.
  always_comb begin
    w_ack_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_ack_hit[i] = (r_state == ST_REQ) && bus.irq_ack && (r_id == ID_W'(i));
    end
  end

  // Scan high to low so the lowest eligible index is the final assignment.
  always_comb begin
    w_sel_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_sel_id = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending  <= '0;
      r_overflow <= '0;
    end else begin
      r_pending  <= bus.evt_pulse | (r_pending & ~w_ack_hit);
      r_overflow <= (bus.evt_pulse & r_pending & ~w_ack_hit) |
                    (r_overflow & ~bus.ovf_clr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_req     <= 1'b0;
      r_id      <= '0;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_elig) begin
            r_id    <= w_sel_id;
            r_req   <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.irq_ack) begin
            r_req     <= 1'b0;
            r_gap_cnt <= GAP_LOAD;
            r_state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.irq_req  = r_req;
  assign bus.irq_id   = r_id;
  assign bus.pending  = r_pending;
  assign bus.overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_irq_req_gen.sv
// ============================================================================
// tb_irq_req_gen : directed self-checking bench for irq_req_gen
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_irq_req_gen;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  irq_req_gen_if #(.NUM_SRC(8), .ID_W(3)) bus_if ();

  irq_req_gen #(.NUM_SRC(8), .ID_W(3), .MIN_GAP(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ack sampled at the next edge (cycle k); returns in cycle k+1.
  task automatic ack_once;
    bus_if.irq_ack = 1'b1;
    tick();
    bus_if.irq_ack = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] v);
    bus_if.evt_pulse = v;
    tick();
    bus_if.evt_pulse = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus_if.evt_pulse = '0;
    bus_if.irq_en    = 8'hFF;
    bus_if.irq_ack   = 1'b0;
    bus_if.ovf_clr   = '0;
    tick();
    tick();
    chk("rst_req",  32'(bus_if.irq_req),  32'h0);
    chk("rst_id",   32'(bus_if.irq_id),   32'h0);
    chk("rst_pend", 32'(bus_if.pending),  32'h0);
    chk("rst_ovf",  32'(bus_if.overflow), 32'h0);
    rst = 1'b0;
    tick();

    // basic latency: event -> pending next cycle -> request the cycle after
    pulse(8'h20);
    chk("lat_pend", 32'(bus_if.pending), 32'h20);
    chk("lat_req0", 32'(bus_if.irq_req), 32'h0);
    tick();
    chk("lat_req1", 32'(bus_if.irq_req), 32'h1);
    chk("lat_id",   32'(bus_if.irq_id),  32'h5);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_req", 32'(bus_if.irq_req), 32'h1);
      chk("hold_id",  32'(bus_if.irq_id),  32'h5);
    end

    // lower-priority arrival waits; gap enforced; spurious ack in GAP ignored
    pulse(8'h02);
    chk("keep_id5", 32'(bus_if.irq_id), 32'h5);
    ack_once();
    chk("gap1_req",  32'(bus_if.irq_req), 32'h0);
    chk("gap1_pend", 32'(bus_if.pending), 32'h02);
    ack_once();
    chk("gap2_req",  32'(bus_if.irq_req), 32'h0);
    chk("gap2_pend", 32'(bus_if.pending), 32'h02);
    tick();
    chk("gap3_req", 32'(bus_if.irq_req), 32'h0);
    tick();
    chk("next_req", 32'(bus_if.irq_req), 32'h1);
    chk("next_id",  32'(bus_if.irq_id),  32'h1);
    ack_once();
    tick(); tick(); tick();
    chk("idle_req",  32'(bus_if.irq_req), 32'h0);
    chk("idle_pend", 32'(bus_if.pending), 32'h0);

    // priority: 2 before 6, late 0 does not preempt 6
    pulse(8'h44);
    chk("pri_pend", 32'(bus_if.pending), 32'h44);
    tick();
    chk("pri_req_a", 32'(bus_if.irq_req), 32'h1);
    chk("pri_id_a",  32'(bus_if.irq_id),  32'h2);
    ack_once();
    tick(); tick(); tick();
    chk("pri_req_b",  32'(bus_if.irq_req), 32'h1);
    chk("pri_id_b",   32'(bus_if.irq_id),  32'h6);
    chk("pri_pend_b", 32'(bus_if.pending), 32'h40);
    pulse(8'h01);
    chk("nopre_req", 32'(bus_if.irq_req), 32'h1);
    chk("nopre_id",  32'(bus_if.irq_id),  32'h6);
    ack_once();
    tick(); tick(); tick();
    chk("pri_req_c", 32'(bus_if.irq_req), 32'h1);
    chk("pri_id_c",  32'(bus_if.irq_id),  32'h0);
    ack_once();
    tick(); tick(); tick();

    // masking, plus spurious ack in IDLE while irq_id still names source 0
    bus_if.irq_en = 8'hF6;
    pulse(8'h09);
    chk("mask_pend", 32'(bus_if.pending), 32'h09);
    ack_once();
    chk("iack_pend", 32'(bus_if.pending), 32'h09);
    chk("iack_req",  32'(bus_if.irq_req), 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("mask_req", 32'(bus_if.irq_req), 32'h0);
    end
    bus_if.irq_en = 8'hFE;
    tick();
    chk("unmask_req", 32'(bus_if.irq_req), 32'h1);
    chk("unmask_id",  32'(bus_if.irq_id),  32'h3);
    ack_once();
    tick(); tick(); tick();
    chk("mask0_req",  32'(bus_if.irq_req), 32'h0);
    chk("mask0_pend", 32'(bus_if.pending), 32'h01);
    bus_if.irq_en = 8'hFF;
    tick();
    chk("unmask0_id", 32'(bus_if.irq_id), 32'h0);
    ack_once();
    tick(); tick(); tick();

    // overflow and ack/event collision on source 4
    pulse(8'h10);
    tick();
    chk("ovf_req", 32'(bus_if.irq_req), 32'h1);
    chk("ovf_id",  32'(bus_if.irq_id),  32'h4);
    pulse(8'h10);
    chk("ovf_set", 32'(bus_if.overflow), 32'h10);
    bus_if.ovf_clr = 8'h10;
    tick();
    bus_if.ovf_clr = '0;
    chk("ovf_clr", 32'(bus_if.overflow), 32'h0);
    bus_if.evt_pulse = 8'h10;
    bus_if.irq_ack   = 1'b1;
    tick();
    bus_if.evt_pulse = '0;
    bus_if.irq_ack   = 1'b0;
    chk("col_pend", 32'(bus_if.pending),  32'h10);
    chk("col_ovf",  32'(bus_if.overflow), 32'h0);
    chk("col_req",  32'(bus_if.irq_req),  32'h0);
    tick(); tick(); tick();
    chk("col_rereq", 32'(bus_if.irq_req), 32'h1);
    chk("col_reid",  32'(bus_if.irq_id),  32'h4);
    bus_if.evt_pulse = 8'h10;
    bus_if.ovf_clr   = 8'h10;
    tick();
    bus_if.evt_pulse = '0;
    bus_if.ovf_clr   = '0;
    chk("ovf_setwin", 32'(bus_if.overflow), 32'h10);

    // asynchronous reset in the middle of a request
    rst = 1'b1;
    #2;
    chk("arst_req",  32'(bus_if.irq_req),  32'h0);
    chk("arst_id",   32'(bus_if.irq_id),   32'h0);
    chk("arst_pend", 32'(bus_if.pending),  32'h0);
    chk("arst_ovf",  32'(bus_if.overflow), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_req", 32'(bus_if.irq_req), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
